bcau_in_buf: RTL and testbench

Receiving end of the IRU output interface. Captures one rotated 5x80 8-bit window from the IRU in a single valid/ready transfer, then streams it pixel-by-pixel in raster order to the BCAU datapath. While draining, it holds the IRU off by deasserting bcau_in_ready.

---
 rtl/bcau_in_buf.sv | 151 +++++++++++++++
 tb/tb_bcau_in_buf.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcau_in_buf.sv
// Window input buffer for the BCAU: captures a ROWS x COLS window from the IRU, then streams it out in raster order.
// Defining BCAU_IN_STATS_EN adds per-window min/max statistics outputs.
module bcau_in_buf #(
  parameter int unsigned ROWS = 5,
  parameter int unsigned COLS = 80,
  parameter int unsigned DW   = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              iru_out_ready,
  input  logic [ROWS-1:0][COLS-1:0][DW-1:0] iru_q,
  output logic                              bcau_in_ready,
  output logic                              pix_valid,
  input  logic                              pix_ready,
  output logic [DW-1:0]                     pix_data,
  output logic                              pix_row_last,
  output logic                              pix_last
`ifdef BCAU_IN_STATS_EN
  ,
  output logic                              stats_valid,
  output logic [DW-1:0]                     pix_min,
  output logic [DW-1:0]                     pix_max
`endif
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                              state;
  logic [RW-1:0]                       row;
  logic [CW-1:0]                       col;
  logic [ROWS-1:0][COLS-1:0][DW-1:0]   mem;
  logic [RW-1:0]                       nrow_c;
  logic [CW-1:0]                       ncol_c;
  logic                                xfer_c;
  logic                                acc_c;

  assign xfer_c = bcau_in_ready & iru_out_ready;
  assign acc_c  = pix_valid & pix_ready;

  // Raster successor of the current (row, col)
  always_comb begin
    nrow_c = row;
    ncol_c = col + CW'(1);
    if (col == COL_MAX) begin
      ncol_c = '0;
      nrow_c = row + RW'(1);
    end
  end

  // Window storage, written only on the transfer edge
  always_ff @(posedge clk) begin
    if (xfer_c) mem <= iru_q;
  end

  // Control FSM; pixel outputs are preloaded from the successor location
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bcau_in_ready <= 1'b1;
      pix_valid     <= 1'b0;
      row           <= '0;
      col           <= '0;
      pix_data      <= '0;
      pix_row_last  <= 1'b0;
      pix_last      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer_c) begin
            state         <= DRAIN;
            bcau_in_ready <= 1'b0;
            pix_valid     <= 1'b1;
            row           <= '0;
            col           <= '0;
            pix_data      <= iru_q[0][0];
            pix_row_last  <= (COLS == 1);
            pix_last      <= (COLS == 1) && (ROWS == 1);
          end
        end
        DRAIN: begin
          if (acc_c) begin
            if (pix_last) begin
              state         <= IDLE;
              bcau_in_ready <= 1'b1;
              pix_valid     <= 1'b0;
              row           <= '0;
              col           <= '0;
              pix_row_last  <= 1'b0;
              pix_last      <= 1'b0;
            end else begin
              row           <= nrow_c;
              col           <= ncol_c;
              pix_data      <= mem[nrow_c][ncol_c];
              pix_row_last  <= (ncol_c == COL_MAX);
              pix_last      <= (ncol_c == COL_MAX) && (nrow_c == ROW_MAX);
            end
          end
        end
        default: begin
          state         <= IDLE;
          bcau_in_ready <= 1'b1;
          pix_valid     <= 1'b0;
        end
      endcase
    end
  end

`ifdef BCAU_IN_STATS_EN
  logic [DW-1:0] run_min;
  logic [DW-1:0] run_max;
  logic [DW-1:0] cmin_c;
  logic [DW-1:0] cmax_c;
  logic          first_c;

  // Running extremes including the pixel being accepted this cycle
  always_comb begin
    first_c = (row == '0) && (col == '0);
    cmin_c  = run_min;
    cmax_c  = run_max;
    if (first_c || (pix_data < run_min)) cmin_c = pix_data;
    if (first_c || (pix_data > run_max)) cmax_c = pix_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min     <= '0;
      run_max     <= '0;
      pix_min     <= '0;
      pix_max     <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      if (acc_c) begin
        run_min <= cmin_c;
        run_max <= cmax_c;
        if (pix_last) begin
          pix_min     <= cmin_c;
          pix_max     <= cmax_c;
          stats_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_bcau_in_buf.sv
// Randomized bench for bcau_in_buf against a raster-order window model.
// Define BCAU_IN_STATS_EN to also check the min/max statistics outputs.
module tb_bcau_in_buf;

  localparam int unsigned ROWS = 5;
  localparam int unsigned COLS = 80;
  localparam int unsigned DW   = 8;
  localparam int unsigned N    = ROWS * COLS;

  logic                              clk;
  logic                              rst_n;
  logic                              iru_out_ready;
  logic [ROWS-1:0][COLS-1:0][DW-1:0] iru_q;
  logic                              bcau_in_ready;
  logic                              pix_valid;
  logic                              pix_ready;
  logic [DW-1:0]                     pix_data;
  logic                              pix_row_last;
  logic                              pix_last;
`ifdef BCAU_IN_STATS_EN
  logic                              stats_valid;
  logic [DW-1:0]                     pix_min;
  logic [DW-1:0]                     pix_max;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] win [ROWS][COLS];

  bcau_in_buf #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .iru_out_ready (iru_out_ready),
    .iru_q         (iru_q),
    .bcau_in_ready (bcau_in_ready),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .pix_row_last  (pix_row_last),
    .pix_last      (pix_last)
`ifdef BCAU_IN_STATS_EN
    ,
    .stats_valid   (stats_valid),
    .pix_min       (pix_min),
    .pix_max       (pix_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 0: ramp (y*80+x)%256, 1: random, 2: all 0xFF, 3: stats pattern
  task automatic fill(input int kind);
    for (int y = 0; y < int'(ROWS); y++)
      for (int x = 0; x < int'(COLS); x++)
        case (kind)
          0:       iru_q[y][x] = 8'((y * int'(COLS) + x) % 256);
          1:       iru_q[y][x] = 8'($urandom);
          2:       iru_q[y][x] = 8'hFF;
          default: iru_q[y][x] = (y == 2 && x == 37) ? 8'h03 :
                                 (y == 4 && x == 79) ? 8'hF0 : 8'h40;
        endcase
  endtask

  task automatic snapshot();
    for (int y = 0; y < int'(ROWS); y++)
      for (int x = 0; x < int'(COLS); x++)
        win[y][x] = iru_q[y][x];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle_valid", 32'(pix_valid), 32'd0);
      check("idle_ready", 32'(bcau_in_ready), 32'd1);
`ifdef BCAU_IN_STATS_EN
      check("idle_stats_valid", 32'(stats_valid), 32'd0);
`endif
      @(negedge clk);
    end
  endtask

  // Starts at an IDLE negedge, ends at the negedge of the first drain cycle
  task automatic send(input bit pulse);
    check("pre_send_ready", 32'(bcau_in_ready), 32'd1);
    snapshot();
    iru_out_ready = 1'b1;
    @(negedge clk);
    if (pulse) iru_out_ready = 1'b0;
  endtask

  // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random; abort_at>0 resets after that many accepts
  task automatic drain(input int mode, input int abort_at);
    int k = 0;
    int vcnt = 0;
    bit done = 0;
    bit aborted = 0;
    bit rdy;
    logic [7:0] mn = 8'hFF;
    logic [7:0] mx = 8'h00;
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      check("drain_valid", 32'(pix_valid), 32'd1);
      check("drain_in_ready", 32'(bcau_in_ready), 32'd0);
      if (pix_valid) begin
        vcnt++;
        check("pix_data", 32'(pix_data), 32'(win[k / int'(COLS)][k % int'(COLS)]));
        check("pix_row_last", 32'(pix_row_last), 32'(k % int'(COLS) == int'(COLS) - 1));
        check("pix_last", 32'(pix_last), 32'(k == int'(N) - 1));
      end
`ifdef BCAU_IN_STATS_EN
      check("drain_stats_valid", 32'(stats_valid), 32'd0);
`endif
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom);
      endcase
      pix_ready = rdy;
      @(negedge clk);
      if (rdy) begin
        k++;
        if (k == int'(N)) done = 1;
        if (abort_at > 0 && k == abort_at) begin
          pix_ready = 1'b0;
          rst_n = 1'b0;
          #1;
          check("rst_valid", 32'(pix_valid), 32'd0);
          check("rst_ready", 32'(bcau_in_ready), 32'd1);
`ifdef BCAU_IN_STATS_EN
          check("rst_stats_valid", 32'(stats_valid), 32'd0);
          check("rst_pix_min", 32'(pix_min), 32'd0);
          check("rst_pix_max", 32'(pix_max), 32'd0);
`endif
          @(negedge clk);
          rst_n = 1'b1;
          done = 1;
          aborted = 1;
        end
      end
    end
    pix_ready = 1'b0;
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    if (done && !aborted) begin
      if (mode == 0) check("valid_cycles", 32'(vcnt), 32'(N));
      check("post_valid", 32'(pix_valid), 32'd0);
      check("post_ready", 32'(bcau_in_ready), 32'd1);
`ifdef BCAU_IN_STATS_EN
      for (int y = 0; y < int'(ROWS); y++)
        for (int x = 0; x < int'(COLS); x++) begin
          if (win[y][x] < mn) mn = win[y][x];
          if (win[y][x] > mx) mx = win[y][x];
        end
      check("stats_valid", 32'(stats_valid), 32'd1);
      check("pix_min", 32'(pix_min), 32'(mn));
      check("pix_max", 32'(pix_max), 32'(mx));
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pix_ready = 1'b0;
    iru_out_ready = 1'b0;
    iru_q = '0;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_ready", 32'(bcau_in_ready), 32'd1);
      check("reset_valid", 32'(pix_valid), 32'd0);
    end
    rst_n = 1'b1;
    idle(10);

    fill(0);
    send(1);
    drain(0, 0);
    idle(2);

    fill(1);
    send(1);
    drain(1, 0);
    idle(2);

    fill(1);
    send(0);
    fill(2);
    drain(0, 0);
    snapshot();
    @(negedge clk);
    iru_out_ready = 1'b0;
    drain(2, 0);
    idle(2);

    fill(1);
    send(1);
    drain(0, 151);
    idle(3);
    fill(1);
    send(1);
    drain(2, 0);
    idle(2);

    fill(3);
    send(1);
    drain(2, 0);
    idle(3);
`ifdef BCAU_IN_STATS_EN
    check("hold_pix_min", 32'(pix_min), 32'h03);
    check("hold_pix_max", 32'(pix_max), 32'hF0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
